// File: rtl/fpga_cfg_pkg.sv
// Shared constants, flat-vector slice offsets and FSM state type for the
// fabric configuration loader.
package fpga_cfg_pkg;
  localparam int DATA_W = 32;
  localparam int BRB_W  = 900;
  localparam int BSB_W  = 1728;
  localparam int LB_W   = 80;
  localparam int IO_W   = 30;

  localparam int TOTAL  = BRB_W + BSB_W + LB_W + 4 * IO_W;
  localparam int NWORDS = (TOTAL + DATA_W - 1) / DATA_W;
  localparam int LAST_W = TOTAL - DATA_W * (NWORDS - 1);
  localparam int IDX_W  = $clog2(NWORDS);
  localparam int OFF_W  = $clog2(TOTAL);

  localparam int BRB_LSB    = 0;
  localparam int BSB_LSB    = BRB_LSB + BRB_W;
  localparam int LB_LSB     = BSB_LSB + BSB_W;
  localparam int LEFT_LSB   = LB_LSB + LB_W;
  localparam int RIGHT_LSB  = LEFT_LSB + IO_W;
  localparam int TOP_LSB    = RIGHT_LSB + IO_W;
  localparam int BOTTOM_LSB = TOP_LSB + IO_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CHECK,
    S_DONE,
    S_ERR
  } state_t;
endpackage

// File: rtl/fpga_cfg_loader_if.sv
// Valid/ready word stream carrying the bitstream into the loader.
interface fpga_cfg_loader_if;
  import fpga_cfg_pkg::*;

  logic [DATA_W-1:0] s_data;
  logic              s_valid;
  logic              s_ready;

  modport master (output s_data, output s_valid, input s_ready);
  modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/fpga_cfg_shadow.sv
// Word-addressed shadow of the flat config vector; padding above TOTAL
// in the final word is never stored.
module fpga_cfg_shadow
  import fpga_cfg_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_we,
  input  logic [IDX_W-1:0]  i_idx,
  input  logic [DATA_W-1:0] i_data,
  output logic [TOTAL-1:0]  o_vec
);
  logic [TOTAL-1:0] r_vec;
  logic [OFF_W-1:0] w_lsb;

  assign w_lsb = OFF_W'(i_idx) * OFF_W'(DATA_W);
  assign o_vec = r_vec;

  // The last word is only partly backed by storage, so it gets its own narrow write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vec <= '0;
    end else if (i_we) begin
      if (i_idx == IDX_W'(NWORDS - 1)) begin
        r_vec[TOTAL-1 -: LAST_W] <= i_data[LAST_W-1:0];
      end else if (i_idx < IDX_W'(NWORDS - 1)) begin
        r_vec[w_lsb +: DATA_W] <= i_data;
      end
    end
  end
endmodule

// File: rtl/fpga_cfg_loader.sv
// Loads a checksummed word stream into a shadow copy and commits it to the
// fabric select buses atomically; a bad load leaves the old config running.
module fpga_cfg_loader
  import fpga_cfg_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  fpga_cfg_loader_if.slave     stream,
  output logic [BRB_W-1:0]     brbselect,
  output logic [BSB_W-1:0]     bsbselect,
  output logic [LB_W-1:0]      lbselect,
  output logic [IO_W-1:0]      leftioselect,
  output logic [IO_W-1:0]      rightioselect,
  output logic [IO_W-1:0]      topioselect,
  output logic [IO_W-1:0]      bottomioselect,
  output logic                 cfg_valid,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);
  state_t            r_state;
  state_t            w_next;
  logic [IDX_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_acc;
  logic [TOTAL-1:0]  r_cfg;
  logic [TOTAL-1:0]  w_shadow;
  logic              r_cfg_valid;
  logic              r_done;
  logic              r_err;
  logic              w_ready;
  logic              w_xfer;
  logic              w_last;
  logic              w_sum_ok;
  logic              w_start_ok;
  logic              w_shadow_we;

  fpga_cfg_shadow u_shadow (
    .clk    (clk),
    .rst    (rst),
    .i_we   (w_shadow_we),
    .i_idx  (r_cnt),
    .i_data (stream.s_data),
    .o_vec  (w_shadow)
  );

  always_comb begin
    w_ready     = (r_state == S_LOAD) || (r_state == S_CHECK);
    w_xfer      = w_ready && stream.s_valid;
    w_last      = (r_cnt == IDX_W'(NWORDS - 1));
    w_sum_ok    = ((r_acc ^ stream.s_data) == '0);
    w_start_ok  = start && !w_ready;
    w_shadow_we = w_xfer && (r_state == S_LOAD);
    w_next      = r_state;
    case (r_state)
      S_IDLE, S_DONE, S_ERR: if (start) w_next = S_LOAD;
      S_LOAD:                if (w_xfer && w_last) w_next = S_CHECK;
      S_CHECK:               if (w_xfer) w_next = w_sum_ok ? S_DONE : S_ERR;
      default:               w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // The checksum word itself is not accumulated; it is compared against the running XOR.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt       <= '0;
      r_acc       <= '0;
      r_cfg       <= '0;
      r_cfg_valid <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_start_ok) begin
        r_cnt <= '0;
        r_acc <= '0;
        r_err <= 1'b0;
      end else if (w_shadow_we) begin
        r_cnt <= r_cnt + 1'b1;
        r_acc <= r_acc ^ stream.s_data;
      end else if (w_xfer) begin
        if (w_sum_ok) begin
          r_cfg       <= w_shadow;
          r_cfg_valid <= 1'b1;
          r_err       <= 1'b0;
          r_done      <= 1'b1;
        end else begin
          r_err <= 1'b1;
        end
      end
    end
  end

  assign stream.s_ready = w_ready;
  assign busy           = w_ready;
  assign done           = r_done;
  assign err            = r_err;
  assign cfg_valid      = r_cfg_valid;
  assign brbselect      = r_cfg[BRB_LSB    +: BRB_W];
  assign bsbselect      = r_cfg[BSB_LSB    +: BSB_W];
  assign lbselect       = r_cfg[LB_LSB     +: LB_W];
  assign leftioselect   = r_cfg[LEFT_LSB   +: IO_W];
  assign rightioselect  = r_cfg[RIGHT_LSB  +: IO_W];
  assign topioselect    = r_cfg[TOP_LSB    +: IO_W];
  assign bottomioselect = r_cfg[BOTTOM_LSB +: IO_W];
endmodule

// File: tb/tb_fpga_cfg_loader.sv
// Directed bench for fpga_cfg_loader: loads are scored against a queue of
// expected outcomes built from an independent flat-vector model.
module tb_fpga_cfg_loader;
  import fpga_cfg_pkg::*;

  typedef struct packed {
    logic             good;
    logic [TOTAL-1:0] cfg;
  } exp_t;

  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic start = 1'b0;

  logic [BRB_W-1:0] brbselect;
  logic [BSB_W-1:0] bsbselect;
  logic [LB_W-1:0]  lbselect;
  logic [IO_W-1:0]  leftioselect, rightioselect, topioselect, bottomioselect;
  logic             cfg_valid, busy, done, err;
  logic [TOTAL-1:0] obsCfg;

  int checks   = 0;
  int failures = 0;
  int cyc;

  logic [DATA_W-1:0] words [NWORDS+1];
  logic [TOTAL-1:0]  committed = '0;
  logic              expValid  = 1'b0;
  exp_t              sbQ [$];

  fpga_cfg_loader_if sif ();

  fpga_cfg_loader dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .stream         (sif),
    .brbselect      (brbselect),
    .bsbselect      (bsbselect),
    .lbselect       (lbselect),
    .leftioselect   (leftioselect),
    .rightioselect  (rightioselect),
    .topioselect    (topioselect),
    .bottomioselect (bottomioselect),
    .cfg_valid      (cfg_valid),
    .busy           (busy),
    .done           (done),
    .err            (err)
  );

  assign obsCfg = {bottomioselect, topioselect, rightioselect, leftioselect,
                   lbselect, bsbselect, brbselect};

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [TOTAL-1:0] obs,
                             input logic [TOTAL-1:0] exp);
    int firstBit;
    checks++;
    assert (obs === exp) else begin
      failures++;
      firstBit = 0;
      for (int i = TOTAL - 1; i >= 0; i--) if (obs[i] !== exp[i]) firstBit = i;
      $display("[TB] FAIL %s: observed bit[%0d]=%b required %b; observed[63:0]=%h required[63:0]=%h",
               tag, firstBit, obs[firstBit], exp[firstBit], obs[63:0], exp[63:0]);
      $error("[TB] check %s", tag);
    end
  endtask

  function automatic logic [TOTAL-1:0] modelCfg();
    logic [NWORDS*DATA_W-1:0] flat;
    for (int k = 0; k < NWORDS; k++) flat[k*DATA_W +: DATA_W] = words[k];
    return flat[TOTAL-1:0];
  endfunction

  function automatic logic [DATA_W-1:0] xorOfWords();
    logic [DATA_W-1:0] acc = '0;
    for (int k = 0; k < NWORDS; k++) acc ^= words[k];
    return acc;
  endfunction

  task automatic buildGood();
    for (int k = 0; k <= NWORDS; k++) words[k] = '0;
    words[0]      = 32'h0000_0030;
    words[88]     = 32'h0000_0001;
    words[NWORDS] = 32'h0000_0031;
  endtask

  // Drives start then nSend words; a full load pushes its expected outcome.
  task automatic applyStimulus(input int nSend, input bit stall, input int startAt,
                               output int cycles);
    exp_t e;
    bit   readyDrop = 1'b0;
    cycles = 0;
    start  = 1'b1;
    tick(); cycles++;
    start  = 1'b0;
    checkOutput("ready_after_start", sif.s_ready, 1'b1);
    checkOutput("err_clear_on_load", err, 1'b0);
    for (int k = 0; k < nSend; k++) begin
      if (stall) begin
        sif.s_valid = 1'b0;
        if (sif.s_ready !== 1'b1 || busy !== 1'b1) readyDrop = 1'b1;
        tick(); cycles++;
      end
      sif.s_valid = 1'b1;
      sif.s_data  = words[k];
      start       = (k == startAt);
      if (sif.s_ready !== 1'b1 || busy !== 1'b1) readyDrop = 1'b1;
      tick(); cycles++;
    end
    sif.s_valid = 1'b0;
    start       = 1'b0;
    checkOutput("ready_held", readyDrop, 1'b0);
    if (nSend == NWORDS + 1) begin
      e.good = (xorOfWords() == words[NWORDS]);
      if (e.good) begin
        committed = modelCfg();
        expValid  = 1'b1;
      end
      e.cfg = committed;
      sbQ.push_back(e);
    end
  endtask

  task automatic collectResult(input string tag);
    exp_t e;
    int   waitCnt = 0;
    while (!(done || err) && waitCnt < 8) begin
      tick();
      waitCnt++;
    end
    checkOutput({tag, "_latency"}, waitCnt, 0);
    if (sbQ.size() == 0) begin
      checkOutput({tag, "_scoreboard_empty"}, 1'b1, 1'b0);
    end else begin
      e = sbQ.pop_front();
      checkOutput({tag, "_done"}, done, e.good);
      checkOutput({tag, "_err"}, err, !e.good);
      checkOutput({tag, "_cfg_valid"}, cfg_valid, expValid);
      checkOutput({tag, "_cfg"}, obsCfg, e.cfg);
      checkOutput({tag, "_busy"}, busy, 1'b0);
      tick();
      checkOutput({tag, "_done_pulse"}, done, 1'b0);
      checkOutput({tag, "_err_hold"}, err, !e.good);
    end
  endtask

  initial begin
    sif.s_valid = 1'b0;
    sif.s_data  = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_cfg", obsCfg, '0);
    checkOutput("rst_cfg_valid", cfg_valid, 1'b0);
    checkOutput("rst_err", err, 1'b0);
    checkOutput("rst_done", done, 1'b0);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_ready", sif.s_ready, 1'b0);
    rst = 1'b0;
    tick();

    $display("[TB] good load");
    buildGood();
    applyStimulus(NWORDS + 1, 1'b0, -1, cyc);
    checkOutput("good_cycles", cyc, 91);
    collectResult("good");
    checkOutput("good_brb_5_4", brbselect[5:4], 2'b11);
    checkOutput("good_bottom_18", bottomioselect[18], 1'b1);

    $display("[TB] reset mid-load");
    applyStimulus(40, 1'b0, -1, cyc);
    #3 rst = 1'b1;
    #1;
    committed = '0;
    expValid  = 1'b0;
    checkOutput("midrst_cfg", obsCfg, '0);
    checkOutput("midrst_cfg_valid", cfg_valid, 1'b0);
    checkOutput("midrst_busy", busy, 1'b0);
    checkOutput("midrst_ready", sif.s_ready, 1'b0);
    #2 rst = 1'b0;
    tick();
    applyStimulus(NWORDS + 1, 1'b0, -1, cyc);
    collectResult("after_rst");

    $display("[TB] stalled load");
    applyStimulus(NWORDS + 1, 1'b1, -1, cyc);
    checkOutput("stall_cycles", cyc, 181);
    collectResult("stalled");

    $display("[TB] bad checksum");
    words[NWORDS] = words[NWORDS] ^ 32'h1;
    applyStimulus(NWORDS + 1, 1'b0, -1, cyc);
    collectResult("bad_csum");

    $display("[TB] padding load started from error");
    buildGood();
    words[88]     = 32'hFFFF_F000;
    words[NWORDS] = 32'h0000_0030 ^ 32'hFFFF_F000;
    applyStimulus(NWORDS + 1, 1'b0, -1, cyc);
    collectResult("padding");
    checkOutput("padding_bottom", bottomioselect, '0);

    $display("[TB] random load with start pulsed mid-load");
    for (int k = 0; k < NWORDS; k++) words[k] = $urandom;
    words[NWORDS] = xorOfWords();
    applyStimulus(NWORDS + 1, 1'b0, 20, cyc);
    checkOutput("midstart_cycles", cyc, 91);
    collectResult("midstart");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "[TB] timeout");
  end
endmodule
